// File: rtl/mode_ctrl_pkg.sv
// Shared encodings for the digital clock: OPTION mode selects, COUNT field
// selects and the mode sequencer state type.
package mode_ctrl_pkg;

  localparam logic [3:0] OPT_NORMAL = 4'b1000;
  localparam logic [3:0] OPT_ALARM  = 4'b0001;
  localparam logic [3:0] OPT_TIME   = 4'b0010;
  localparam logic [3:0] OPT_SW     = 4'b0100;

  localparam logic [3:0] FLD_NONE = 4'b0000;
  localparam logic [3:0] FLD_MIN  = 4'b0001;
  localparam logic [3:0] FLD_HOUR = 4'b0010;

  // State codes equal the OPTION encodings so the state flops drive OPTION directly
  typedef enum logic [3:0] {
    ST_NORMAL = OPT_NORMAL,
    ST_ALARM  = OPT_ALARM,
    ST_TIME   = OPT_TIME,
    ST_SW     = OPT_SW
  } state_t;

  function automatic logic is_set(input state_t s);
    return (s == ST_ALARM) || (s == ST_TIME);
  endfunction

endpackage

// File: rtl/mode_ctrl_btn_edge.sv
// Rising-edge detector for one push-button; LAST resets high so a button
// held through reset release yields no pulse.
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last  <= 1'b1;
      pulse <= 1'b0;
    end else begin
      last  <= btn;
      pulse <= btn & ~last;
    end
  end

endmodule

// File: rtl/mode_ctrl.sv
// Mode and field sequencer: button edges drive the NORMAL/ALARM/TIME/STOPWATCH
// FSM, field select, display blink and idle timeout back to NORMAL.
module mode_ctrl
  import mode_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 1000,
  parameter int unsigned TIMEOUT_S = 10
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       MODE,
  input  logic       SEL,
  input  logic       U,
  input  logic       D,
  output logic [3:0] OPTION,
  output logic [3:0] COUNT,
  output logic       BLINK
);

  localparam int unsigned PW   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IW   = 6;
  localparam int unsigned HALF = CLK_DIV / 2;

  logic en_mode, en_sel, en_u, en_d;

  btn_edge u_mode (.clk(CLK), .rst_n(RESETN), .btn(MODE), .pulse(en_mode));
  btn_edge u_sel  (.clk(CLK), .rst_n(RESETN), .btn(SEL),  .pulse(en_sel));
  btn_edge u_up   (.clk(CLK), .rst_n(RESETN), .btn(U),    .pulse(en_u));
  btn_edge u_dn   (.clk(CLK), .rst_n(RESETN), .btn(D),    .pulse(en_d));

  state_t          state_q, state_d;
  logic [3:0]      count_d;
  logic            blink_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [IW-1:0]   idle_q, idle_d;
  logic            tick_c, activity_c, timeout_c, entry_c;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= ST_NORMAL;
      COUNT   <= FLD_NONE;
      BLINK   <= 1'b1;
      presc_q <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      COUNT   <= count_d;
      BLINK   <= blink_d;
      presc_q <= presc_d;
      idle_q  <= idle_d;
    end
  end

  assign OPTION = state_q;

  // Next state, field select, blink, prescaler and idle counter
  always_comb begin
    state_d    = state_q;
    count_d    = COUNT;
    blink_d    = BLINK;
    idle_d     = idle_q;
    tick_c     = (presc_q == PW'(CLK_DIV - 1));
    presc_d    = tick_c ? '0 : presc_q + PW'(1);
    activity_c = en_mode | en_sel | en_u | en_d;
    // U/D on the firing cycle count as fresh activity and cancel the timeout
    timeout_c  = is_set(state_q) && (idle_q == IW'(TIMEOUT_S)) && !en_u && !en_d;

    if (en_mode) begin
      case (state_q)
        ST_NORMAL: begin state_d = ST_ALARM;  count_d = FLD_MIN;  end
        ST_ALARM:  begin state_d = ST_TIME;   count_d = FLD_MIN;  end
        ST_TIME:   begin state_d = ST_SW;     count_d = FLD_NONE; end
        default:   begin state_d = ST_NORMAL; count_d = FLD_NONE; end
      endcase
    end else if (timeout_c) begin
      state_d = ST_NORMAL;
      count_d = FLD_NONE;
    end else if (en_sel && is_set(state_q)) begin
      count_d = (COUNT == FLD_MIN) ? FLD_HOUR : FLD_MIN;
    end

    entry_c = (state_d != state_q);

    if (entry_c || !is_set(state_q) || activity_c)
      idle_d = '0;
    else if (tick_c && (idle_q < IW'(TIMEOUT_S)))
      idle_d = idle_q + IW'(1);

    if (entry_c || !is_set(state_q) || en_sel)
      blink_d = 1'b1;
    else if ((presc_q == '0) || (presc_q == PW'(HALF)))
      blink_d = ~BLINK;
  end

endmodule

// File: tb/tb_mode_ctrl.sv
// Directed bench for mode_ctrl with CLK_DIV=10, TIMEOUT_S=3.
module tb_mode_ctrl;
  import mode_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode = 1'b0, sel = 1'b0, up = 1'b0, dn = 1'b0;
  logic [3:0] option, count;
  logic       blink;

  int checks = 0;
  int errors = 0;
  int pm = 0;
  int edge_pm = 0;
  bit tick_seen = 1'b0;

  mode_ctrl #(.CLK_DIV(10), .TIMEOUT_S(3)) dut (
    .CLK(clk), .RESETN(rst_n), .MODE(mode), .SEL(sel), .U(up), .D(dn),
    .OPTION(option), .COUNT(count), .BLINK(blink)
  );

  always #5 clk = ~clk;

  // One clock edge; tracks the expected prescaler value alongside the DUT
  task automatic step();
    @(posedge clk);
    edge_pm   = pm;
    tick_seen = (pm == 9);
    if (!rst_n) pm = 0;
    else        pm = tick_seen ? 0 : pm + 1;
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // which: 0 MODE, 1 SEL, 2 U
  task automatic press(input int which);
    if (which == 0) mode = 1'b1; else if (which == 1) sel = 1'b1; else up = 1'b1;
    step();
    mode = 1'b0; sel = 1'b0; up = 1'b0;
    step();
  endtask

  task automatic wait_ticks(input int nt);
    int n = 0;
    int t = 0;
    while (t < nt && n < 200) begin
      step();
      n++;
      if (tick_seen) t++;
    end
  endtask

  initial begin
    logic [3:0] exp_opt [4];
    logic [3:0] exp_cnt [4];
    logic [3:0] prev_opt;
    logic       bl;
    exp_opt = '{OPT_ALARM, OPT_TIME, OPT_SW, OPT_NORMAL};
    exp_cnt = '{FLD_MIN, FLD_MIN, FLD_NONE, FLD_NONE};

    steps(2);
    rst_n = 1'b1;
    pm = 0;
    chk("reset_option", option, OPT_NORMAL);
    chk("reset_count", count, FLD_NONE);
    chk("reset_blink", {3'b000, blink}, 4'b0001);
    steps(2);

    // Mode cycling with two-edge latency
    prev_opt = OPT_NORMAL;
    for (int i = 0; i < 4; i++) begin
      mode = 1'b1;
      step();
      chk("mode_latency", option, prev_opt);
      mode = 1'b0;
      step();
      chk("mode_option", option, exp_opt[i]);
      chk("mode_count", count, exp_cnt[i]);
      prev_opt = exp_opt[i];
      steps(2);
    end

    // SEL ignored in NORMAL
    press(1);
    chk("sel_normal_count", count, FLD_NONE);
    chk("sel_normal_option", option, OPT_NORMAL);
    steps(2);

    // Field select in ALARM_SET
    press(0);
    chk("alarm_entry", option, OPT_ALARM);
    steps(3);
    press(1);
    chk("sel1_count", count, FLD_HOUR);
    chk("sel1_blink", {3'b000, blink}, 4'b0001);
    steps(2);
    press(1);
    chk("sel2_count", count, FLD_MIN);
    chk("sel2_blink", {3'b000, blink}, 4'b0001);

    // Blink toggles when the prescaler passes 0 and 5
    bl = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (edge_pm == 0 || edge_pm == 5) bl = ~bl;
      chk("blink_toggle", {3'b000, blink}, {3'b000, bl});
    end

    // MODE and SEL together: only the mode change
    mode = 1'b1; sel = 1'b1;
    step();
    mode = 1'b0; sel = 1'b0;
    step();
    chk("simul_option", option, OPT_TIME);
    chk("simul_count", count, FLD_MIN);
    steps(2);
    press(0); steps(2);
    press(0); steps(2);
    chk("back_normal", option, OPT_NORMAL);

    // Timeout from TIME_SET
    press(0); steps(2);
    press(0);
    chk("time_entry", option, OPT_TIME);
    wait_ticks(3);
    chk("timeout_not_yet", option, OPT_TIME);
    step();
    chk("timeout_option", option, OPT_NORMAL);
    chk("timeout_count", count, FLD_NONE);
    steps(2);

    // Timeout deferral by U
    press(0); steps(2);
    press(0);
    wait_ticks(2);
    steps(2);
    press(2);
    wait_ticks(3);
    chk("defer_still_set", option, OPT_TIME);
    step();
    chk("defer_timeout", option, OPT_NORMAL);
    steps(2);

    // Held MODE: exactly one advance
    press(0); steps(2);
    press(0); steps(2);
    mode = 1'b1;
    steps(50);
    chk("held_option", option, OPT_SW);
    chk("held_count", count, FLD_NONE);
    mode = 1'b0;
    steps(2);
    press(0); steps(2);
    chk("held_release_next", option, OPT_NORMAL);
    press(0); steps(2);
    press(0); steps(2);
    chk("pre_reset_option", option, OPT_TIME);

    // Asynchronous reset mid-TIME_SET with MODE held
    mode = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_option", option, OPT_NORMAL);
    chk("async_reset_count", count, FLD_NONE);
    chk("async_reset_blink", {3'b000, blink}, 4'b0001);
    steps(2);
    rst_n = 1'b1;
    pm = 0;
    steps(5);
    chk("no_adv_after_reset", option, OPT_NORMAL);
    mode = 1'b0;
    steps(2);
    press(0);
    chk("fresh_press", option, OPT_ALARM);
    chk("fresh_press_count", count, FLD_MIN);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mode_ctrl.md
# mode_ctrl

Top-level mode and field sequencer for the digital clock. It turns the MODE and SEL push-buttons into the one-hot OPTION and COUNT selects consumed by the alarm-set, time-set and stopwatch blocks. It also generates a field-blink enable for the display. In the set modes it returns to normal display after a configurable period with no button activity.

## Interface
- CLK_DIV, default 1000: CLK cycles per one-second tick; must be even and ≥ 2.
- TIMEOUT_S, default 10: seconds of no button activity in a set mode before returning to NORMAL; range 1..63.

- CLK  in  1  system clock, rising-edge.
- RESETN  in  1  asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- MODE  in  1  mode button, level, synchronous to CLK.
- SEL  in  1  field-select button, level.
- U  in  1  up button, level; used only for activity tracking.
- D  in  1  down button, level; used only for activity tracking.
- OPTION  out  4  one-hot mode:
  - 1000 NORMAL
  - 0001 ALARM_SET
  - 0010 TIME_SET
  - 0100 STOPWATCH
- COUNT  out  4  field select:
  - 0001 minute
  - 0010 hour
  - 0000 none
- BLINK  out  1  1 = selected field visible, 0 = blanked.

## Operation
- **Edge detection.** Each button X has LAST_X and EN_X registers; every clock, LAST_X <= X and EN_X <= X & ~LAST_X. On reset, LAST_* are set to 1, so a button held through reset release produces no edge. EN_* are cleared to 0.
- **Activity.** Activity is defined as any of EN_MODE, EN_SEL, EN_U or EN_D being high.
- **State machine.** States are NORMAL, ALARM_SET, TIME_SET and STOPWATCH. OPTION is decoded from the state.
  - EN_MODE advances the state NORMAL -> ALARM_SET -> TIME_SET -> STOPWATCH -> NORMAL.
  - Entering ALARM_SET or TIME_SET sets COUNT = 0001.
  - Entering NORMAL or STOPWATCH sets COUNT = 0000.
- **Field select.** EN_SEL in ALARM_SET or TIME_SET toggles COUNT between 0001 and 0010. EN_SEL in NORMAL or STOPWATCH is ignored.
- **Second tick.** A prescaler counts 0..CLK_DIV-1 and free-runs in every state. It produces a one-cycle TICK when the count wraps.
- **Timeout counter.** An idle-seconds counter is active only in ALARM_SET and TIME_SET.
  - It clears on activity and on every state entry.
  - It increments on TICK and saturates at TIMEOUT_S.
  - When it reaches TIMEOUT_S, the next clock forces NORMAL with COUNT = 0000.
- **Blink.** In set modes, BLINK toggles each CLK_DIV/2 cycles, using the prescaler count at 0 and at CLK_DIV/2. BLINK is forced to 1 on state entry, on EN_SEL, and in NORMAL and STOPWATCH.
- **Priority**, highest first:
  1. Reset.
  2. EN_MODE.
  3. Timeout.
  4. EN_SEL.
- **Simultaneous events.**
  - EN_MODE together with EN_SEL: only the mode change happens.
  - EN_MODE together with timeout in ALARM_SET: the state goes to TIME_SET, not NORMAL.
  - EN_U or EN_D on the same cycle the timeout would fire: the idle counter clears and no timeout occurs.

## Timing
- **Reset values:**
  - OPTION = 1000, COUNT = 0000, BLINK = 1.
  - Prescaler = 0, idle counter = 0.
  - EN_* = 0, LAST_* = 1.
- **Button latency.** MODE is first sampled high at rising edge k, so EN_MODE is high after edge k. OPTION and COUNT change at edge k+1. The change is visible 2 edges after the first high sample.
- **Held buttons.** A button held high generates exactly one EN pulse. A new pulse requires the button to be sampled low for at least one edge.
- **Timeout latency.** The idle counter reaches TIMEOUT_S on a TICK edge. OPTION becomes 1000 on the following edge.
- **Registered outputs.** All outputs are registered with no combinational input-to-output path.
- **Reset mid-operation.** Reset returns all outputs to their reset values immediately, asynchronously. The first state change after release requires a fresh button edge.

## Structure
- Shared clock package holds:
  - the OPTION encodings (OPT_NORMAL, OPT_ALARM, OPT_TIME, OPT_SW);
  - the COUNT encodings (FLD_NONE, FLD_MIN, FLD_HOUR).

  ALARM_SET and the other set blocks import the same constants.
- Sub-module btn_edge (one instance per button) contains the LAST/EN pair with reset-to-1 LAST. The prescaler, idle counter and FSM stay in mode_ctrl.

## Test plan
Run with CLK_DIV = 10 and TIMEOUT_S = 3.

- **Mode cycling:** reset, then pulse MODE 4 times with ≥ 2 low cycles between pulses -> OPTION follows 0001, 0010, 0100, 1000 and COUNT follows 0001, 0001, 0000, 0000. Each change lands 2 edges after MODE rises.
- **Field select:** in ALARM_SET, pulse SEL twice -> COUNT goes 0010 then 0001 and BLINK = 1 right after each pulse. SEL in NORMAL -> COUNT stays 0000.
- **Timeout:** enter TIME_SET and stay idle -> OPTION = 1000 on the edge after the 3rd TICK following entry.
- **Timeout deferral:** U pulse before the 3rd TICK -> timeout is pushed to 3 full ticks after the U pulse.
- **Simultaneous / held buttons:**
  - MODE and SEL rising on the same edge in ALARM_SET -> OPTION = 0010, COUNT = 0001.
  - MODE held 50 cycles -> exactly one advance.
- **Blink and reset:**
  - In ALARM_SET, BLINK toggles every 5 cycles.
  - Assert RESETN low mid-TIME_SET with MODE held high -> OPTION = 1000 immediately, and no advance after release until MODE is released and pressed again.
